v810_bus_ram: RTL and testbench
===============================

# v810_bus_ram

Responder (slave) end of the V810 external memory bus: a word-organised RAM that answers bus cycles started by `v810_mem` with READYn/SZRQn handshakes. Wait-state count and 16/32-bit bus width are selectable at run time. The block sits opposite `v810_mem` on the A/D/BEn/DAn/MRQn/RW/BCYSTn/READYn/SZRQn bus and replaces ad-hoc bench memories in system and device benches.

## Interface
- AW, 10, word-address width; the array holds 2^AW 32-bit words indexed by A[AW+1:2]. Array name is `mem`, and benches may access it hierarchically.
- CLK  in  1  clock.
- RES  in  1  asynchronous, active-high reset.
- CE  in  1  clock enable. State advances only on CLK rising edges with CE=1.
- A  in  32  bus address.
- D_I  in  32  write data from the master.
- D_O  out  32  read data to the master.
- BEn  in  4  byte enables, active low. Bit i selects lane [8i+7:8i].
- DAn  in  1  data phase strobe, active low.
- MRQn  in  1  memory request, active low.
- RW  in  1  1 = read, 0 = write.
- BCYSTn  in  1  bus cycle start (T1), active low.
- READYn  out  1  data phase complete, active low.
- SZRQn  out  1  16-bit size request, active low.
- WS  in  3  wait states (0–7), sampled at cycle start.
- DW16  in  1  1 = responder is a 16-bit device, sampled at cycle start.
- ERR  out  1  sticky protocol-error flag.

## Operation
- **States:** IDLE and BUSY. Captured registers: `ca` (word address), `crw`, `cben`, `cdw16`, `cnt[2:0]`, `rdata[31:0]`.
- **Start (IDLE):**
  - An edge with MRQn=0 and BCYSTn=0 captures A, RW, BEn, DW16, and WS into `cnt`.
  - The same edge latches `rdata <= mem[A[AW+1:2]]`.
  - The state moves to BUSY.
- **BUSY:**
  - `done = ~DAn & (cnt==0)`.
  - An edge with DAn=0 and cnt≠0 decrements `cnt`.
  - An edge with `done` completes the cycle:
    - If crw=0, perform the write (see lane rules).
    - Go to IDLE, or capture a new cycle directly if MRQn=0 and BCYSTn=0 on that same edge (back-to-back).
  - BCYSTn=0 in BUSY without `done` is a protocol error: set ERR and ignore the new start.
  - DAn high simply holds the state; there is no timeout.
- **READYn:** combinational, `READYn = ~(BUSY & done)`.
- **SZRQn:** combinational, `SZRQn = ~(BUSY & cdw16 & done)`.
- **32-bit lanes (cdw16=0):**
  - Read: `D_O = rdata`.
  - Write: byte i is written from D_I[8i+7:8i] when cben[i]=0.
- **16-bit lanes (cdw16=1):**
  - Low half is selected when cben is 1110, 1101, 1100 or 0000; every other value selects the high half.
  - Low-half read: `D_O = {16'h0, rdata[15:0]}`.
  - Low-half write: bytes 0/1 are written from D_I[7:0]/D_I[15:8] per cben[1:0]. cben=0000 writes both bytes.
  - High-half read: `D_O = {16'h0, rdata[31:16]}`.
  - High-half write: bytes 2/3 are written from D_I[7:0]/D_I[15:8] per cben[3:2].
  - Each halfword is a separate bus cycle with its own BCYSTn.
- **D_O when idle:** D_O = 0 unless BUSY & crw=1.
- **Read/write collision:** a write completing in the same edge as a back-to-back start to the same word returns the pre-write word (read-before-write). The master does not depend on this.

## Timing
- **Reset:**
  - Outputs: READYn=1, SZRQn=1, D_O=0, ERR=0.
  - Internal state: IDLE, cnt=0, and all captured registers 0.
  - `mem` is not cleared.
  - RES asserted mid-cycle abandons the cycle, and no write occurs.
- **Latency:**
  - With WS=n, READYn goes low in the (n+1)-th CE cycle in which DAn is low, counting from the first cycle with DAn low after T1.
  - WS=0: READYn goes low in the same cycle DAn first goes low (combinational).
- **Write commit:** write data is sampled and written on the edge where READYn=0 and DAn=0.
- **CE=0:** freezes `cnt`, state, `rdata` and `mem`. READYn still follows DAn combinationally from frozen state.
- **Minimum cycle:** back-to-back cycles sustain one transfer per T1+T2 pair (WS=0).

## Test plan
- **32-bit, WS=0 read:**
  - Stimulus: mem[1]=32'hDEADBEEF; start T1 at A=32'h4, RW=1, BEn=0000; DAn low next cycle.
  - Required: READYn low that same cycle, D_O=32'hDEADBEEF, SZRQn=1.
- **32-bit, WS=2 write:**
  - Stimulus: A=32'hC, BEn=1100, D_I=32'h11223344.
  - Required: READYn low on the 3rd DAn-low cycle; mem[3][15:0]=16'h3344; mem[3][31:16] unchanged.
- **16-bit, WS=1 split word:**
  - Stimulus: read A=32'h8 with BEn=1100, then with BEn=0011; mem[2]=32'hAAAA5555.
  - Required: D_O=32'h00005555 then 32'h0000AAAA; SZRQn low only during each READYn-low cycle.
- **16-bit high-half write:**
  - Stimulus: BEn=0011, D_I=32'h0000BEEF to A=32'h10.
  - Required: mem[4][31:16]=16'hBEEF; mem[4][15:0] unchanged.
- **Protocol error:**
  - Stimulus: BCYSTn=0 while BUSY with DAn high.
  - Required: ERR=1 and stays 1; the original cycle still completes normally.
- **Reset mid-write:**
  - Stimulus: RES=1 during the DAn-low wait cycle with WS=3.
  - Required: target word unchanged; READYn=1 immediately; next cycle after reset release works normally.

Source files
------------

// File: rtl/v810_bus_ram.sv
// V810 external-bus responder: word-organised RAM answering MRQn/BCYSTn/DAn cycles
// with READYn/SZRQn, run-time wait states and 16/32-bit bus width.
module v810_bus_ram #(
   parameter int AW = 10
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        CE,
   input  logic [31:0] A,
   input  logic [31:0] D_I,
   output logic [31:0] D_O,
   input  logic [3:0]  BEn,
   input  logic        DAn,
   input  logic        MRQn,
   input  logic        RW,
   input  logic        BCYSTn,
   output logic        READYn,
   output logic        SZRQn,
   input  logic [2:0]  WS,
   input  logic        DW16,
   output logic        ERR,
   output logic        o_dbg_state
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   logic [31:0] mem [2**AW];

   state_t        r_state;
   state_t        w_next_state;
   logic [AW-1:0] r_ca;
   logic          r_crw;
   logic [3:0]    r_cben;
   logic          r_cdw16;
   logic [2:0]    r_cnt;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_busy;
   logic          w_start;
   logic          w_done;
   logic          w_capture;
   logic          w_dec;
   logic          w_proto_err;
   logic          w_low_half;
   logic          w_we;
   logic [3:0]    w_lane_we;
   logic [31:0]   w_wdata;
   logic          w_unused_bits;

   assign w_unused_bits = ^{A[31:AW+2], A[1:0]};

   assign w_busy      = (r_state == ST_BUSY);
   assign w_start     = ~MRQn & ~BCYSTn;
   assign w_done      = w_busy & ~DAn & (r_cnt == 3'd0);
   // A new cycle is accepted from IDLE, or on the completing edge of the current one.
   assign w_capture   = CE & w_start & (~w_busy | w_done);
   assign w_dec       = CE & w_busy & ~DAn & (r_cnt != 3'd0);
   assign w_proto_err = CE & w_busy & ~BCYSTn & ~w_done;
   assign w_we        = CE & w_done & ~r_crw;

   assign w_low_half  = (r_cben == 4'b1110) || (r_cben == 4'b1101) ||
                        (r_cben == 4'b1100) || (r_cben == 4'b0000);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_next_state = ST_BUSY;
         ST_BUSY: if (w_done)  w_next_state = w_start ? ST_BUSY : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // On a 16-bit device the master always drives the active halfword on D_I[15:0].
   always_comb begin
      w_lane_we = ~r_cben;
      w_wdata   = D_I;
      if (r_cdw16) begin
         if (w_low_half) begin
            w_lane_we = {2'b00, ~r_cben[1:0]};
            w_wdata   = {16'h0000, D_I[15:0]};
         end else begin
            w_lane_we = {~r_cben[3:2], 2'b00};
            w_wdata   = {D_I[15:0], 16'h0000};
         end
      end
   end

   always_comb begin
      D_O = 32'h0000_0000;
      if (w_busy && r_crw) begin
         if (!r_cdw16)       D_O = r_rdata;
         else if (w_low_half) D_O = {16'h0000, r_rdata[15:0]};
         else                D_O = {16'h0000, r_rdata[31:16]};
      end
   end

   assign READYn      = ~w_done;
   assign SZRQn       = ~(w_done & r_cdw16);
   assign ERR         = r_err;
   assign o_dbg_state = r_state;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_state <= ST_IDLE;
         r_ca    <= '0;
         r_crw   <= 1'b0;
         r_cben  <= 4'h0;
         r_cdw16 <= 1'b0;
         r_cnt   <= 3'd0;
         r_rdata <= 32'h0000_0000;
         r_err   <= 1'b0;
      end else begin
         if (CE) r_state <= w_next_state;
         if (w_capture) begin
            r_ca    <= A[AW+1:2];
            r_crw   <= RW;
            r_cben  <= BEn;
            r_cdw16 <= DW16;
            r_cnt   <= WS;
            r_rdata <= mem[A[AW+1:2]];
         end else if (w_dec) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_proto_err) r_err <= 1'b1;
      end
   end

   // No reset on the array: contents survive RES, and a reset mid-cycle kills w_done.
   always_ff @(posedge CLK) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_lane_we[i]) mem[r_ca][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_v810_bus_ram.sv
// Directed bench for v810_bus_ram: driver tasks issue bus cycles and queue the
// expected {SZRQn, D_O}; a negedge monitor checks every READYn-low cycle.
module tb_v810_bus_ram;

   logic        CLK = 1'b0;
   logic        RES = 1'b1;
   logic        CE = 1'b1;
   logic [31:0] A = '0;
   logic [31:0] D_I = '0;
   logic [31:0] D_O;
   logic [3:0]  BEn = 4'hF;
   logic        DAn = 1'b1;
   logic        MRQn = 1'b1;
   logic        RW = 1'b1;
   logic        BCYSTn = 1'b1;
   logic        READYn;
   logic        SZRQn;
   logic [2:0]  WS = 3'd0;
   logic        DW16 = 1'b0;
   logic        ERR;
   logic        dbg_state;

   int n_chk = 0;
   int n_pass = 0;
   logic [32:0] exp_q[$];

   v810_bus_ram #(.AW(10)) dut (
      .CLK(CLK), .RES(RES), .CE(CE), .A(A), .D_I(D_I), .D_O(D_O), .BEn(BEn),
      .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(READYn),
      .SZRQn(SZRQn), .WS(WS), .DW16(DW16), .ERR(ERR), .o_dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every READYn-low cycle consumes one expected {SZRQn, D_O}.
   always @(negedge CLK) begin
      logic [32:0] e;
      if (!RES) begin
         if (READYn === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("d_o", D_O, e[31:0]);
               chk("szrqn", {31'b0, SZRQn}, {31'b0, e[32]});
            end
         end else begin
            chk("szrqn_idle", {31'b0, SZRQn}, 32'd1);
         end
      end
   end

   // Called just after a rising edge; leaves the bus idle just after a rising edge.
   task automatic do_cycle(input logic [31:0] addr, input logic rw, input logic [3:0] ben,
                           input logic [31:0] wd, input logic [2:0] ws, input logic dw16,
                           input logic [31:0] exp_d, input int stall, input logic stray,
                           input int freeze);
      int lat;
      int exp_lat;
      exp_lat = int'(ws) + 1 + freeze;
      A = addr; RW = rw; BEn = ben; D_I = wd; WS = ws; DW16 = dw16;
      MRQn = 1'b0; BCYSTn = 1'b0; DAn = 1'b1;
      exp_q.push_back({~dw16, (rw ? exp_d : 32'h0)});
      @(posedge CLK); #1;
      BCYSTn = 1'b1;
      for (int s = 0; s < stall; s++) begin
         if (stray) begin
            BCYSTn = 1'b0;
            A = addr + 32'h4;
         end
         @(posedge CLK); #1;
         BCYSTn = 1'b1;
         A = addr;
      end
      DAn = 1'b0;
      CE = (freeze > 0) ? 1'b0 : 1'b1;
      lat = 1;
      forever begin
         @(negedge CLK);
         if (!READYn) break;
         if (lat > 20) break;
         @(posedge CLK); #1;
         lat++;
         CE = (lat <= freeze) ? 1'b0 : 1'b1;
      end
      chk("latency", lat, exp_lat);
      @(posedge CLK); #1;
      CE = 1'b1; DAn = 1'b1; MRQn = 1'b1; BEn = 4'hF;
   endtask

   task automatic wr32(input logic [31:0] addr, input logic [31:0] wd);
      do_cycle(addr, 1'b0, 4'b0000, wd, 3'd0, 1'b0, 32'h0, 0, 1'b0, 0);
   endtask

   task automatic rd32(input logic [31:0] addr, input logic [31:0] exp_d);
      do_cycle(addr, 1'b1, 4'b0000, 32'h0, 3'd0, 1'b0, exp_d, 0, 1'b0, 0);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_readyn", {31'b0, READYn}, 32'd1);
      chk("rst_szrqn", {31'b0, SZRQn}, 32'd1);
      chk("rst_d_o", D_O, 32'h0);
      chk("rst_err", {31'b0, ERR}, 32'd0);
      chk("rst_state", {31'b0, dbg_state}, 32'd0);
      @(posedge CLK); #1;
      RES = 1'b0;
      @(posedge CLK); #1;

      wr32(32'h4,  32'hDEADBEEF);
      wr32(32'h8,  32'hAAAA5555);
      wr32(32'hC,  32'hA5A5A5A5);
      wr32(32'h10, 32'h87654321);
      wr32(32'h1C, 32'h0BADC0DE);

      // 32-bit WS=0 read, then WS=2 partial write and read-back.
      rd32(32'h4, 32'hDEADBEEF);
      do_cycle(32'hC, 1'b0, 4'b1100, 32'h11223344, 3'd2, 1'b0, 32'h0, 0, 1'b0, 0);
      rd32(32'hC, 32'hA5A53344);

      // 16-bit WS=1 split read of one word.
      do_cycle(32'h8, 1'b1, 4'b1100, 32'h0, 3'd1, 1'b1, 32'h00005555, 0, 1'b0, 0);
      do_cycle(32'h8, 1'b1, 4'b0011, 32'h0, 3'd1, 1'b1, 32'h0000AAAA, 0, 1'b0, 0);

      // 16-bit high-half write, then single-byte low-half write (BEn=1101 -> byte 1).
      do_cycle(32'h10, 1'b0, 4'b0011, 32'h0000BEEF, 3'd0, 1'b1, 32'h0, 0, 1'b0, 0);
      rd32(32'h10, 32'hBEEF4321);
      do_cycle(32'h10, 1'b0, 4'b1101, 32'h0000AB00, 3'd0, 1'b1, 32'h0, 0, 1'b0, 0);
      rd32(32'h10, 32'hBEEFAB21);

      // CE=0 during the first DAn-low cycle stretches WS=1 by one cycle.
      do_cycle(32'h4, 1'b1, 4'b0000, 32'h0, 3'd1, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1);

      // Reset in the middle of a WS=3 write.
      A = 32'h1C; RW = 1'b0; BEn = 4'b0000; D_I = 32'hCAFEF00D; WS = 3'd3; DW16 = 1'b0;
      MRQn = 1'b0; BCYSTn = 1'b0; DAn = 1'b1;
      @(posedge CLK); #1;
      BCYSTn = 1'b1; DAn = 1'b0;
      @(posedge CLK); #1;
      RES = 1'b1;
      #1;
      chk("midrst_readyn", {31'b0, READYn}, 32'd1);
      chk("midrst_state", {31'b0, dbg_state}, 32'd0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RES = 1'b0; MRQn = 1'b1; DAn = 1'b1; BEn = 4'hF;
      @(posedge CLK); #1;
      chk("midrst_mem", dut.mem[7], 32'h0BADC0DE);
      rd32(32'h1C, 32'h0BADC0DE);

      // Stray BCYSTn while waiting with DAn high: ERR sets, cycle still completes.
      do_cycle(32'h14, 1'b0, 4'b0000, 32'h12345678, 3'd1, 1'b0, 32'h0, 2, 1'b1, 0);
      @(negedge CLK);
      chk("err_set", {31'b0, ERR}, 32'd1);
      @(posedge CLK); #1;
      rd32(32'h14, 32'h12345678);

      // Back-to-back reads: second T1 on the completing edge of the first.
      A = 32'h4; RW = 1'b1; BEn = 4'b0000; WS = 3'd0; DW16 = 1'b0;
      MRQn = 1'b0; BCYSTn = 1'b0; DAn = 1'b1;
      exp_q.push_back({1'b1, 32'hDEADBEEF});
      exp_q.push_back({1'b1, 32'hAAAA5555});
      @(posedge CLK); #1;
      DAn = 1'b0; A = 32'h8;
      @(posedge CLK); #1;
      BCYSTn = 1'b1;
      @(posedge CLK); #1;
      DAn = 1'b1; MRQn = 1'b1;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("queue_empty", exp_q.size(), 32'd0);
      chk("err_sticky", {31'b0, ERR}, 32'd1);
      chk("end_state", {31'b0, dbg_state}, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
